weight_hs_rr_arbiter: RTL and testbench
=======================================

// Module: weight_hs_rr_arbiter
// PURPOSE
//  - N:1 valid/ready arbiter that merges REQ_NUM single-bit streams onto one output stream.
//  - Grants are weighted round robin. Each grant lasts for up to WEIGHTS[i] transfers (USE_LAST=0) or WEIGHTS[i] packets (USE_LAST=1).
//  - A grant is never switched mid-packet.
//  - Sits in front of an AXI-style channel as a stream merge point.
// PARAMETERS
//  REQ_NUM   8               number of requesters (>=2)
//  USE_LAST  1'b1            1: a grant unit is a packet ending on last_in; 0: a grant unit is a single beat
//  WEIGHT_W  4               width of each weight field
//  WEIGHTS   {REQ_NUM{4'd1}} packed REQ_NUM*WEIGHT_W vector; field i = grant units for requester i; 0 is treated as 1
// PORTS
//  clk          in   1        single clock, rising edge
//  rstn         in   1        asynchronous active-low reset
//  valid_in     in   REQ_NUM  per-requester valid
//  payload_in   in   REQ_NUM  per-requester 1-bit payload
//  last_in      in   REQ_NUM  per-requester end-of-packet (ignored when USE_LAST=0)
//  ready_out    in   1        downstream ready
//  ready_in     out  REQ_NUM  per-requester ready; at most one bit set
//  valid_out    out  1        downstream valid
//  payload_out  out  1        payload of the granted requester
//  last_out     out  1        last of the granted requester; 0 when USE_LAST=0
// BEHAVIOUR
//  - State registers:
//    - ptr: round-robin start index
//    - owner: index of the current grantee
//    - locked: grant is held
//    - cnt (WEIGHT_W bits): grant units completed in the current grant
//  - Reset (async, rstn=0): ptr=0, owner=0, locked=0, cnt=0.
//    - While rstn=0: valid_out=0, ready_in=0, payload_out=0, last_out=0.
//  - Selection when locked=0 (combinational):
//    - sel = first i with valid_in[i]=1, scanning ptr, ptr+1, ... modulo REQ_NUM.
//    - If no valid_in is set: valid_out=0 and ready_in=0.
//  - Selection when locked=1: sel = owner, whatever the other valids are.
//  - Datapath, zero latency:
//    - valid_out=valid_in[sel], payload_out=payload_in[sel].
//    - last_out=last_in[sel]&USE_LAST.
//    - ready_in=onehot(sel)&{REQ_NUM{ready_out}}.
//    - No combinational path from ready_out to valid_out.
//  - fire = valid_out & ready_out. Requesters hold valid and payload until they are fired.
//  - Unit completion: unit_done = fire & (USE_LAST ? last_in[sel] : 1).
//  - On a fire with unit_done=1 and cnt+1 >= weight(sel) (the grant ends):
//    - locked<=0, cnt<=0, ptr<=(sel+1) mod REQ_NUM.
//  - On any other fire: locked<=1, owner<=sel, cnt<=cnt+unit_done.
//  - Mid-packet: with USE_LAST=1, a grant whose current beat has last_in=0 stays locked.
//  - No fire: state holds. An idle grantee (valid dropped while locked) keeps its grant; there is no timeout.
//  - Wrap-around: ptr and owner increment modulo REQ_NUM. sel=REQ_NUM-1 ending its grant gives ptr=0.
//  - Reset asserted mid-packet aborts the grant; the arbiter restarts from ptr=0.
//  - A 1-beat packet (last_in=1 on the first beat) with weight 1 completes without ever setting locked.
// CONFIGURATION
//  - Macro WEIGHT_HS_RR_ARB_SVA_EN defined: compile in concurrent assertions, clocked on clk and disabled by !rstn:
//    - $onehot0(ready_in)
//    - valid_out & !ready_out |=> $stable(payload_out) & valid_out
//    - locked |-> sel==owner
//    - ready_in[i] implies valid_out equals valid_in[i]
//  - Macro undefined: no assertion code. Function and ports are identical in both builds.
// TESTING
//  - Reset: rstn=0 with valid_in=8'hFF -> ready_in=0 and valid_out=0. After release, the first grant goes to req0.
//  - Fairness: USE_LAST=0, weights 1, valid_in=8'hFF, ready_out=1 -> grants 0,1,...,7,0 on consecutive cycles.
//  - Packet lock: USE_LAST=1; req2 starts a 4-beat packet (last on beat 4); req5 stays valid throughout.
//    -> ready_in[5] stays 0 until req2's last fires; req5 is granted on the next cycle.
//  - Weight: USE_LAST=0, WEIGHTS[3]=3; req3 and req4 continuously valid.
//    -> 3 beats from req3, then 1 from req4, then 3 from req3.
//  - Backpressure: ready_out=0 for 5 cycles mid-packet -> valid_out and payload_out stable; sel unchanged; no fire counted.
//  - Wrap and sparse requests: only req7 and req0 valid, ptr=7 -> order 7,0,7,0.
//    - Random valid/ready over 10 us: no packet is interleaved.

Source files
------------

// File: rtl/weight_hs_rr_arbiter.sv
// Weighted round-robin valid/ready stream merge with packet-level grant locking.
// Optional concurrent assertions are compiled in when WEIGHT_HS_RR_ARB_SVA_EN is defined.
module weight_hs_rr_arbiter #(
   parameter int                          REQ_NUM  = 8,
   parameter bit                          USE_LAST = 1'b1,
   parameter int                          WEIGHT_W = 4,
   parameter logic [REQ_NUM*WEIGHT_W-1:0] WEIGHTS  = {REQ_NUM{4'd1}}
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [REQ_NUM-1:0] valid_in,
   input  logic [REQ_NUM-1:0] payload_in,
   input  logic [REQ_NUM-1:0] last_in,
   input  logic               ready_out,
   output logic [REQ_NUM-1:0] ready_in,
   output logic               valid_out,
   output logic               payload_out,
   output logic               last_out
);

   localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic                locked_q, locked_d;
   logic [WEIGHT_W-1:0] cnt_q, cnt_d;

   logic [IDX_W:0]      pick_s;
   logic [IDX_W-1:0]    sel_s;
   logic                grant_ok_s;
   logic                fire_s;
   logic                unit_done_s;
   logic [WEIGHT_W:0]   cnt_inc_s;
   logic                grant_end_s;

   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned      off);
      int unsigned sum;
      sum = 32'(base) + off;
      sum = (sum >= 32'(REQ_NUM)) ? (sum - 32'(REQ_NUM)) : sum;
      return sum[IDX_W-1:0];
   endfunction

   // Returns {hit, index} of the first request found scanning upward from base.
   function automatic logic [IDX_W:0] rr_pick(input logic [REQ_NUM-1:0] req,
                                              input logic [IDX_W-1:0]   base);
      logic             hit;
      logic [IDX_W-1:0] pick;
      logic [IDX_W-1:0] cand;
      hit  = 1'b0;
      pick = base;
      for (int k = 0; k < REQ_NUM; k++) begin
         cand = wrap_add(base, 32'(k));
         pick = (!hit && req[cand]) ? cand : pick;
         hit  = hit | req[cand];
      end
      return {hit, pick};
   endfunction

   // A zero weight field still grants one unit.
   function automatic logic [WEIGHT_W:0] weight_of(input logic [IDX_W-1:0] idx);
      logic [WEIGHT_W-1:0] w;
      w = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         w = (idx == IDX_W'(i)) ? WEIGHTS[i*WEIGHT_W +: WEIGHT_W] : w;
      end
      return (w == '0) ? {{WEIGHT_W{1'b0}}, 1'b1} : {1'b0, w};
   endfunction

   // Grant selection: the owner while locked, otherwise the round-robin winner.
   always_comb begin
      pick_s     = rr_pick(valid_in, ptr_q);
      sel_s      = locked_q ? owner_q : pick_s[IDX_W-1:0];
      grant_ok_s = locked_q | pick_s[IDX_W];
   end

   // Zero-latency datapath; ready_out only reaches ready_in, never valid_out.
   always_comb begin
      valid_out   = rstn & valid_in[sel_s];
      payload_out = rstn & payload_in[sel_s];
      last_out    = rstn & last_in[sel_s] & USE_LAST;
      ready_in    = {{(REQ_NUM-1){1'b0}}, 1'b1} << sel_s;
      ready_in    = ready_in & {REQ_NUM{ready_out & grant_ok_s & rstn}};
   end

   // Grant bookkeeping: count completed units and release the grant once the weight is used up.
   always_comb begin
      fire_s      = valid_out & ready_out;
      unit_done_s = fire_s & (USE_LAST ? last_in[sel_s] : 1'b1);
      cnt_inc_s   = {1'b0, cnt_q} + {{WEIGHT_W{1'b0}}, 1'b1};
      grant_end_s = unit_done_s & (cnt_inc_s >= weight_of(sel_s));
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      locked_d    = locked_q;
      cnt_d       = cnt_q;
      if (grant_end_s) begin
         locked_d = 1'b0;
         cnt_d    = '0;
         ptr_d    = wrap_add(sel_s, 32'd1);
      end else if (fire_s) begin
         locked_d = 1'b1;
         owner_d  = sel_s;
         cnt_d    = cnt_q + WEIGHT_W'(unit_done_s);
      end else begin
         locked_d = locked_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_q    <= '0;
         owner_q  <= '0;
         locked_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         locked_q <= locked_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef WEIGHT_HS_RR_ARB_SVA_EN
   a_rdy_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(ready_in));
   a_hold: assert property (@(posedge clk) disable iff (!rstn)
      (valid_out & !ready_out) |=> ($stable(payload_out) & valid_out));
   a_lock_owner: assert property (@(posedge clk) disable iff (!rstn) locked_q |-> (sel_s == owner_q));
   for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_rdy_chk
      a_rdy_valid: assert property (@(posedge clk) disable iff (!rstn)
         ready_in[gi] |-> (valid_out == valid_in[gi]));
   end
`else
`endif

endmodule

// File: tb/tb_weight_hs_rr_arbiter.sv
// Directed and random scoreboard bench for weight_hs_rr_arbiter (three parameterisations).
module tb_weight_hs_rr_arbiter;

   typedef struct packed {
      logic [7:0] rdy;
      logic       v;
      logic       p;
      logic       l;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] valid_in, payload_in, last_in;
   logic       ready_out;
   logic [7:0] rdy_a, rdy_b, rdy_c;
   logic       vo_a, vo_b, vo_c, po_a, po_b, po_c, lo_a, lo_b, lo_c;

   exp_t  sb_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;
   int    mon = 0;

   int         rem[8];
   logic [7:0] pay;
   logic [7:0] er;
   logic [2:0] pkt_owner, fi;
   bit         in_pkt, fired, ok;

   always #5 clk = ~clk;

   weight_hs_rr_arbiter #(.REQ_NUM(8), .USE_LAST(1'b0), .WEIGHT_W(4), .WEIGHTS(32'h1111_1111)) u_a (
      .clk(clk), .rstn(rstn), .valid_in(valid_in), .payload_in(payload_in), .last_in(last_in),
      .ready_out(ready_out), .ready_in(rdy_a), .valid_out(vo_a), .payload_out(po_a), .last_out(lo_a));

   weight_hs_rr_arbiter #(.REQ_NUM(8), .USE_LAST(1'b1), .WEIGHT_W(4), .WEIGHTS(32'h1111_1111)) u_b (
      .clk(clk), .rstn(rstn), .valid_in(valid_in), .payload_in(payload_in), .last_in(last_in),
      .ready_out(ready_out), .ready_in(rdy_b), .valid_out(vo_b), .payload_out(po_b), .last_out(lo_b));

   weight_hs_rr_arbiter #(.REQ_NUM(8), .USE_LAST(1'b0), .WEIGHT_W(4), .WEIGHTS(32'h1111_3111)) u_c (
      .clk(clk), .rstn(rstn), .valid_in(valid_in), .payload_in(payload_in), .last_in(last_in),
      .ready_out(ready_out), .ready_in(rdy_c), .valid_out(vo_c), .payload_out(po_c), .last_out(lo_c));

   function automatic exp_t observed();
      case (mon)
         0:       return {rdy_a, vo_a, po_a, lo_a};
         1:       return {rdy_b, vo_b, po_b, lo_b};
         2:       return {rdy_c, vo_c, po_c, lo_c};
         default: return '0;
      endcase
   endfunction

   task automatic expect_push(input string tag, input logic [7:0] r, input logic v, input logic p,
                              input logic l);
      sb_q.push_back({r, v, p, l});
      tag_q.push_back(tag);
   endtask

   task automatic check_pop();
      exp_t  e;
      exp_t  g;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      g = observed();
      checks++;
      assert (g === e) else begin
         errors++;
         $error("FAIL %s dut%0d observed rdy=%h v=%b p=%b l=%b expected rdy=%h v=%b p=%b l=%b",
                t, mon, g.rdy, g.v, g.p, g.l, e.rdy, e.v, e.p, e.l);
      end
   endtask

   task automatic step(input string tag, input logic [7:0] v, input logic [7:0] p, input logic [7:0] l,
                       input logic r, input logic [7:0] erdy, input logic ev, input logic ep,
                       input logic el);
      @(posedge clk);
      #2;
      valid_in   = v;
      payload_in = p;
      last_in    = l;
      ready_out  = r;
      expect_push(tag, erdy, ev, ep, el);
      #2;
      check_pop();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn       = 1'b0;
      valid_in   = 8'h00;
      payload_in = 8'h00;
      last_in    = 8'h00;
      ready_out  = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      rstn       = 1'b0;
      valid_in   = 8'hFF;
      payload_in = 8'hFF;
      last_in    = 8'hFF;
      ready_out  = 1'b1;
      #1;
      for (int m = 0; m < 3; m++) begin
         mon = m;
         expect_push("reset_out", 8'h00, 1'b0, 1'b0, 1'b0);
         check_pop();
      end
      @(posedge clk);
      #2;
      mon = 1;
      expect_push("reset_hold", 8'h00, 1'b0, 1'b0, 1'b0);
      check_pop();
      @(negedge clk);
      rstn = 1'b1;
      #1;
      expect_push("first_grant_b", 8'h01, 1'b1, 1'b1, 1'b1);
      check_pop();
      mon = 0;
      expect_push("first_grant_a", 8'h01, 1'b1, 1'b1, 1'b0);
      check_pop();

      // Fairness: single-beat units, all weights 1, everyone valid.
      do_reset();
      mon = 0;
      for (int k = 0; k < 9; k++) begin
         step("fair", 8'hFF, 8'hB2, 8'hFF, 1'b1, 8'h01 << (k % 8), 1'b1, ((8'hB2 >> (k % 8)) & 8'h01) != 8'h00, 1'b0);
      end

      // Packet lock with mid-packet backpressure and a late higher-priority requester.
      do_reset();
      mon = 1;
      step("pkt_b1", 8'h24, 8'h24, 8'h20, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0);
      step("pkt_b2", 8'h24, 8'h20, 8'h20, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step("pkt_bp", 8'h25, 8'h25, 8'h21, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      end
      step("pkt_b3", 8'h25, 8'h25, 8'h21, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0);
      step("pkt_b4", 8'h25, 8'h21, 8'h25, 1'b1, 8'h04, 1'b1, 1'b0, 1'b1);
      step("pkt_next5", 8'h21, 8'h21, 8'h21, 1'b1, 8'h20, 1'b1, 1'b1, 1'b1);
      step("pkt_next0", 8'h01, 8'h01, 8'h01, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
      step("pkt_idle", 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      // Grantee goes idle mid-packet and keeps the grant.
      step("idle_b1", 8'h02, 8'h02, 8'h00, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0);
      step("idle_gap", 8'h08, 8'h08, 8'h08, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
      step("idle_end", 8'h0A, 8'h0A, 8'h0A, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1);
      step("idle_next", 8'h08, 8'h08, 8'h08, 1'b1, 8'h08, 1'b1, 1'b1, 1'b1);

      // Weight 3 on req3 against weight 1 on req4.
      do_reset();
      mon = 2;
      for (int k = 0; k < 8; k++) begin
         er = ((k % 4) == 3) ? 8'h10 : 8'h08;
         step("weight", 8'h18, ((k % 2) == 1) ? 8'h08 : 8'h10, 8'hFF, 1'b1, er, 1'b1,
              (er & (((k % 2) == 1) ? 8'h08 : 8'h10)) != 8'h00, 1'b0);
      end

      // Wrap-around with sparse requesters starting from ptr=7.
      do_reset();
      mon = 0;
      step("wrap_pre", 8'h40, 8'h40, 8'h00, 1'b1, 8'h40, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         step("wrap", 8'h81, 8'h80, 8'h00, 1'b1, ((k % 2) == 0) ? 8'h80 : 8'h01, 1'b1, (k % 2) == 0, 1'b0);
      end

      // Random packets with backpressure: a started packet must finish before anyone else fires.
      do_reset();
      mon = 1;
      for (int i = 0; i < 8; i++) rem[i] = 0;
      pay       = 8'h00;
      in_pkt    = 1'b0;
      fired     = 1'b0;
      fi        = 3'd0;
      pkt_owner = 3'd0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         @(posedge clk);
         #2;
         if (fired) begin
            rem[fi] = rem[fi] - 1;
            pay[fi] = 1'($urandom_range(0, 1));
         end
         for (int i = 0; i < 8; i++) begin
            if (rem[i] == 0 && $urandom_range(0, 2) == 0) rem[i] = int'($urandom_range(1, 4));
            valid_in[i] = (rem[i] != 0);
            last_in[i]  = (rem[i] == 1);
         end
         payload_in = pay;
         ready_out  = ($urandom_range(0, 3) != 0);
         if (in_pkt) begin
            expect_push("rand_lock", ready_out ? (8'h01 << pkt_owner) : 8'h00, 1'b1, pay[pkt_owner],
                        last_in[pkt_owner]);
         end
         #2;
         fi = 3'd0;
         for (int i = 0; i < 8; i++) begin
            if (rdy_b[i]) fi = 3'(i);
         end
         fired = vo_b & ready_out & (rdy_b != 8'h00);
         if (in_pkt) begin
            check_pop();
         end else begin
            ok = $onehot0(rdy_b) && ((vo_b & ready_out) == (rdy_b != 8'h00)) &&
                 (rdy_b == 8'h00 || (valid_in[fi] && po_b === payload_in[fi] && lo_b === last_in[fi]));
            checks++;
            assert (ok) else begin
               errors++;
               $error("FAIL rand_free observed rdy=%h v=%b p=%b l=%b expected onehot grant of a valid requester with its data",
                      rdy_b, vo_b, po_b, lo_b);
            end
         end
         if (fired) begin
            in_pkt    = !last_in[fi];
            pkt_owner = fi;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
